// File: rtl/register_file_rename_if.sv
// Issue, commit and operand-read signals between issue logic, the ROB and the
// renaming register file. The register file takes the slave side.
interface register_file_rename_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 rdy_in;
  logic                 clear_signal;

  logic                 issue_signal;
  logic                 issue_rd_valid;
  logic [4:0]           issue_rd_id;
  logic [ROB_WIDTH-1:0] issue_rob_tag;

  logic                 reg_done;
  logic [31:0]          reg_value;
  logic [4:0]           reg_id;
  logic [ROB_WIDTH-1:0] reg_tag;

  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;

  modport master (
    output rdy_in, clear_signal,
    output issue_signal, issue_rd_valid, issue_rd_id, issue_rob_tag,
    output reg_done, reg_value, reg_id, reg_tag,
    output rs1_id, rs2_id,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy_in, clear_signal,
    input  issue_signal, issue_rd_valid, issue_rd_id, issue_rob_tag,
    input  reg_done, reg_value, reg_id, reg_tag,
    input  rs1_id, rs2_id,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags. Commits from the ROB
// retire values and release renames; issue reads see value-or-tag with commit forwarding.
module register_file_rename #(
  parameter int ROB_WIDTH = 4
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  register_file_rename_if.slave rf
);

  localparam int NUM_REGS = 32;

  logic [31:0]          value_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [ROB_WIDTH-1:0] tag_q   [NUM_REGS];

  logic commit_en;
  logic issue_en;

  assign commit_en = rf.reg_done && (rf.reg_id != 5'd0);
  assign issue_en  = rf.issue_signal && rf.issue_rd_valid &&
                     (rf.issue_rd_id != 5'd0) && !rf.clear_signal;

  // Later non-blocking assignments to the same register override earlier ones,
  // which is how a same-cycle issue out-ranks the commit's busy release.
  // NOTE: sequential state uses <= only, so every read in this block sees the
  // pre-edge value regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: the storage array is reset explicitly because every register,
      // not only the busy bits, must read 0 straight out of reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else if (rf.rdy_in) begin
      if (commit_en) begin
        value_q[rf.reg_id] <= rf.reg_value;
        if (busy_q[rf.reg_id] && (tag_q[rf.reg_id] == rf.reg_tag)) begin
          busy_q[rf.reg_id] <= 1'b0;
        end
      end
      if (rf.clear_signal) begin
        busy_q <= '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_q[i] <= '0;
        end
      end else if (issue_en) begin
        busy_q[rf.issue_rd_id] <= 1'b1;
        tag_q[rf.issue_rd_id]  <= rf.issue_rob_tag;
      end
    end
  end

  logic [4:0]           rs_id    [2];
  logic [31:0]          rd_value [2];
  logic                 rd_busy  [2];
  logic [ROB_WIDTH-1:0] rd_tag   [2];

  assign rs_id[0] = rf.rs1_id;
  assign rs_id[1] = rf.rs2_id;

  // A commit that resolves the pending producer this cycle is forwarded, so the
  // consumer never waits an extra cycle for the register write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: every output gets a default before the conditional overrides so
      // no path leaves a value unassigned and no latch is inferred.
      rd_value[p] = value_q[rs_id[p]];
      rd_busy[p]  = busy_q[rs_id[p]];
      rd_tag[p]   = busy_q[rs_id[p]] ? tag_q[rs_id[p]] : '0;
      if (rs_id[p] == 5'd0) begin
        rd_value[p] = '0;
        rd_busy[p]  = 1'b0;
        rd_tag[p]   = '0;
      end else if (rf.reg_done && (rf.reg_id == rs_id[p]) && busy_q[rs_id[p]] &&
                   (tag_q[rs_id[p]] == rf.reg_tag)) begin
        rd_value[p] = rf.reg_value;
        rd_busy[p]  = 1'b0;
        rd_tag[p]   = '0;
      end
    end
  end

  assign rf.rs1_value = rd_value[0];
  assign rf.rs1_busy  = rd_busy[0];
  assign rf.rs1_tag   = rd_tag[0];
  assign rf.rs2_value = rd_value[1];
  assign rf.rs2_busy  = rd_busy[1];
  assign rf.rs2_tag   = rd_tag[1];

endmodule
